// File: rtl/line_length_packer.sv
// Length accumulator that tracks the output-word fill level and drives the packing
// shifter with store, word-output and zero-pad flush commands for each cache line.
module line_length_packer #(
  parameter int unsigned CACHE_LINE = 512,
  parameter int unsigned WORD_SIZE  = 64,
  parameter int unsigned LEN_W      = 7,
  localparam int unsigned MAX_WORDS = CACHE_LINE / WORD_SIZE,
  localparam int unsigned SH_W      = $clog2(WORD_SIZE),
  localparam int unsigned CNT_W     = $clog2(MAX_WORDS + 1)
) (
  input  logic             i_clk,
  input  logic             i_reset,
  input  logic             i_valid,
  input  logic [LEN_W-1:0] i_length,
  input  logic             i_last,
  output logic             o_ready,
  output logic             o_store_flag,
  output logic [SH_W-1:0]  o_shift_amount,
  output logic             o_output_flag,
  output logic             o_fill_flag,
  output logic             o_done_flag,
  output logic [CNT_W-1:0] o_word_count,
  output logic [SH_W-1:0]  o_tail_bits,
  output logic             o_overflow
);

  localparam int unsigned SUM_W = SH_W + 2;

  typedef enum logic [1:0] {
    ACCUM = 2'd0,
    SPILL = 2'd1,
    FLUSH = 2'd2,
    DONE  = 2'd3
  } state_t;

  state_t           state;
  logic [SH_W-1:0]  fill;
  logic [CNT_W-1:0] cnt;
  logic             ovf;
  logic             last_pending;
  logic [SH_W-1:0]  tail;

  logic [SUM_W-1:0] sum;
  logic [1:0]       nwords;
  logic [SH_W-1:0]  sum_fill;
  logic             accept;
  logic             pulse_req;
  logic             pulse_ok;
  logic             pulse_ovf;

  assign o_ready  = (state == ACCUM);
  assign accept   = i_valid && (state == ACCUM);
  assign sum      = SUM_W'(fill) + SUM_W'(i_length);
  assign nwords   = sum[SUM_W-1:SH_W];
  assign sum_fill = sum[SH_W-1:0];

  // A word-output opportunity; only the first MAX_WORDS of a line are emitted.
  assign pulse_req = (accept && (nwords != 2'd0)) || (state == SPILL) || (state == FLUSH);
  assign pulse_ok  = pulse_req && !ovf && (cnt != CNT_W'(MAX_WORDS));
  assign pulse_ovf = pulse_req && !ovf && (cnt == CNT_W'(MAX_WORDS));

  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) begin
      state          <= ACCUM;
      fill           <= '0;
      cnt            <= '0;
      ovf            <= 1'b0;
      last_pending   <= 1'b0;
      tail           <= '0;
      o_store_flag   <= 1'b0;
      o_shift_amount <= '0;
      o_output_flag  <= 1'b0;
      o_fill_flag    <= 1'b0;
      o_done_flag    <= 1'b0;
      o_word_count   <= '0;
      o_tail_bits    <= '0;
      o_overflow     <= 1'b0;
    end else begin
      o_store_flag  <= 1'b0;
      o_output_flag <= 1'b0;
      o_fill_flag   <= 1'b0;
      o_done_flag   <= 1'b0;
      o_word_count  <= '0;
      o_tail_bits   <= '0;
      o_overflow    <= 1'b0;

      if (pulse_ok) cnt <= cnt + CNT_W'(1);
      if (pulse_ovf) ovf <= 1'b1;

      case (state)
        ACCUM: begin
          if (i_valid) begin
            fill           <= sum_fill;
            o_store_flag   <= 1'b1;
            o_shift_amount <= fill;
            o_output_flag  <= pulse_ok;
            last_pending   <= i_last;
            if (nwords == 2'd2) begin
              state <= SPILL;
            end else if (i_last) begin
              state <= (sum_fill != '0) ? FLUSH : DONE;
            end
          end
        end
        SPILL: begin
          o_output_flag <= pulse_ok;
          if (last_pending) begin
            state <= (fill != '0) ? FLUSH : DONE;
          end else begin
            state <= ACCUM;
          end
        end
        FLUSH: begin
          o_output_flag <= pulse_ok;
          o_fill_flag   <= pulse_ok;
          tail          <= fill;
          fill          <= '0;
          state         <= DONE;
        end
        DONE: begin
          o_done_flag  <= 1'b1;
          o_word_count <= cnt;
          o_tail_bits  <= tail;
          o_overflow   <= ovf;
          cnt          <= '0;
          ovf          <= 1'b0;
          tail         <= '0;
          last_pending <= 1'b0;
          state        <= ACCUM;
        end
        default: state <= ACCUM;
      endcase
    end
  end

endmodule

// File: doc/line_length_packer.md
# line_length_packer

Parametrised successor to the compressor's length accumulator. It takes one variable-length code length per handshake and tracks the bit fill of the output word. For every accepted code it drives the datapath with a store/shift command, one or two word-output commands, and an end-of-line zero-pad flush. At end of line it reports the compressed word count and flags lines that exceed the uncompressed cache-line size. It sits between the Stage-2 length encoder and the Stage-3 packing shifter.

## Interface
- CACHE_LINE, 512, uncompressed line size in bits; multiple of WORD_SIZE.
- WORD_SIZE, 64, output word width in bits; power of two.
- LEN_W, 7, input length width; 2**LEN_W-1 must not exceed 2*WORD_SIZE.
- Derived: MAX_WORDS = CACHE_LINE/WORD_SIZE; SH_W = $clog2(WORD_SIZE); CNT_W = $clog2(MAX_WORDS+1).
- i_clk, in, 1, clock; all state changes on the rising edge.
- i_reset, in, 1, asynchronous, active-high reset.
- i_valid, in, 1, i_length/i_last valid.
- i_length, in, LEN_W, code length in bits; 0 is legal.
- i_last, in, 1, last code of the cache line.
- o_ready, out, 1, block accepts a code; handshake = i_valid && o_ready.
- o_store_flag, out, 1, pulse: datapath ORs the code into staging at o_shift_amount.
- o_shift_amount, out, SH_W, bit offset of the accepted code (fill before accept).
- o_output_flag, out, 1, pulse: staging low word complete; push it and shift staging down by WORD_SIZE.
- o_fill_flag, out, 1, pulse coincident with the flush o_output_flag; word is zero-padded.
- o_done_flag, out, 1, pulse: line finished; o_word_count, o_tail_bits and o_overflow valid.
- o_word_count, out, CNT_W, words emitted for the line, saturating at MAX_WORDS.
- o_tail_bits, out, SH_W, valid bits in the last word; 0 means the last word is full.
- o_overflow, out, 1, line needs more than MAX_WORDS words; sticky until done.

## Operation
- Registers: state, fill[SH_W], word counter, overflow, last_pending, and the fill captured for the tail.
- States: ACCUM, SPILL, FLUSH, DONE. o_ready = (state == ACCUM). While o_ready = 0, i_valid is ignored.
- ACCUM, on handshake:
  - sum = fill + i_length, computed at SH_W+2 bits.
  - nwords = sum >> SH_W, range 0..2.
  - fill <= sum mod WORD_SIZE.
  - Register o_store_flag = 1 and o_shift_amount = old fill.
  - Register o_output_flag = (nwords >= 1).
  - last_pending <= i_last.
- ACCUM next state:
  - SPILL if nwords == 2.
  - Otherwise, if i_last: FLUSH if new fill != 0, else DONE.
  - Otherwise ACCUM.
- SPILL: register o_output_flag; then go to FLUSH/DONE (using last_pending and fill, same rule as above) or to ACCUM.
- FLUSH: register o_output_flag and o_fill_flag; capture tail = fill; fill <= 0; go to DONE.
- DONE: register o_done_flag with the count, tail and overflow outputs; clear the counter, overflow and tail; go to ACCUM.
- Word counter increments on every output pulse.
  - The pulse that would be word MAX_WORDS+1 sets overflow instead.
  - Once overflow is set, all further o_output_flag and o_fill_flag pulses are suppressed.
  - o_store_flag pulses continue.
- A zero-length code produces a store pulse only. A line of all zero-length codes finishes with o_word_count = 0 and no output pulse.

## Timing
- All outputs are registered.
- Reset values:
  - state = ACCUM, so o_ready = 1.
  - All flags 0.
  - o_shift_amount, o_word_count and o_tail_bits 0.
  - o_overflow 0; fill and counters 0.
- A pulse is high for exactly the one cycle after the edge that produced it.
- Handshake at edge E0: store (and first output, if any) are visible in cycle E0+1.
- With no spill or flush, throughput is one code per cycle.
- Each SPILL, FLUSH and DONE state costs one cycle with o_ready = 0.
- Latency from the last handshake to o_done_flag:
  - 1 cycle with no spill and no flush.
  - 2 cycles with a flush or with a spill.
  - 3 cycles with both a spill and a flush.
- o_word_count, o_tail_bits and o_overflow are valid only while o_done_flag = 1; they read 0 otherwise.
- Reset asserted mid-line discards the line. All outputs take their reset values asynchronously, and there is no done pulse.

## Test plan
- Reset then idle:
  - All outputs 0 and o_ready = 1.
  - i_valid = 0 for 5 cycles: no pulses.
- 40, 12, 12 (last):
  - Shifts 0, 40, 52.
  - o_output_flag only on the third code.
  - Done one cycle later: word_count = 1, tail = 0, fill_flag never set.
- 48, 8, 68 (last):
  - Shifts 0, 48, 56.
  - Output on the third code.
  - Flush pulse with fill_flag.
  - Done: word_count = 2, tail = 60.
- 60, 127 (last):
  - Shift 60 on the second code; output pulses on two consecutive cycles (accept, then SPILL).
  - Then a flush pulse with fill_flag.
  - o_ready low for 3 cycles.
  - Done: word_count = 3, tail = 59.
- Nine codes of 64 bits, ninth with last:
  - Eight output pulses, the ninth suppressed.
  - Done: word_count = 8, o_overflow = 1.
  - Next line: o_overflow = 0.
- Reset mid-line:
  - Reset asserted after one accepted 40-bit code.
  - Then 24 (last): shift 0, flush, done with word_count = 1, tail = 24.
